// File: rtl/hydra_ingress_buffer.sv
// Packet ingress buffer: stores framed packets, commits only length-correct ones,
// and replays committed packets on a framed output with out_ready backpressure.
module hydra_ingress_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int PORT_BITS  = 4,
    parameter int PRI_BITS   = 3,
    parameter int LEN_BITS   = 9,
    parameter int DEPTH      = 256,
    parameter int PAUSE_TH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_sop,
    input  logic                     wr_vld,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_eop,
    output logic                     pause,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_vld,
    output logic                     out_eop,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [PORT_BITS-1:0]     out_dest,
    output logic [PRI_BITS-1:0]      out_pri,
    output logic [15:0]              pkt_cnt,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   free_words
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int CW      = ((LEN_BITS > PW) ? LEN_BITS : PW) + 1;
    localparam int LEN_LSB = PORT_BITS + PRI_BITS;

    typedef enum logic [1:0] {W_IDLE, W_HDR, W_BODY, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_SOP, R_DATA, R_EOP}  r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t            w_state, w_state_n;
    r_state_t            r_state, r_state_n;
    logic [PW-1:0]       wr_ptr, wr_ptr_n, cwr_ptr, cwr_ptr_n, rd_ptr, rd_ptr_n;
    logic [CW-1:0]       w_cnt, w_cnt_n, r_cnt, r_cnt_n;
    logic [LEN_BITS-1:0] w_len, w_len_n, r_len;
    logic [PW-1:0]       pend;
    logic [PW-1:0]       free_n;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                wr_en, commit, drop, rd_start, full;

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign free_words = PW'(DEPTH) - (wr_ptr - rd_ptr);
    assign free_n     = PW'(DEPTH) - (wr_ptr_n - rd_ptr_n);
    assign rd_word    = mem[rd_ptr[AW-1:0]];

    // Write side: wr_ptr runs ahead for the open packet, cwr_ptr marks the committed end.
    always_comb begin
        w_state_n = w_state;
        wr_ptr_n  = wr_ptr;
        cwr_ptr_n = cwr_ptr;
        w_cnt_n   = w_cnt;
        w_len_n   = w_len;
        wr_en     = 1'b0;
        commit    = 1'b0;
        drop      = 1'b0;
        case (w_state)
            W_IDLE: if (wr_sop) w_state_n = W_HDR;
            W_HDR, W_BODY: begin
                if (wr_sop) begin
                    drop      = 1'b1;
                    wr_ptr_n  = cwr_ptr;
                    w_state_n = W_HDR;
                end else if (wr_eop) begin
                    w_state_n = W_IDLE;
                    if (w_state == W_BODY && w_cnt == CW'(w_len)) begin
                        commit    = 1'b1;
                        cwr_ptr_n = wr_ptr;
                    end else begin
                        drop     = 1'b1;
                        wr_ptr_n = cwr_ptr;
                    end
                end else if (wr_vld) begin
                    if (full) begin
                        wr_ptr_n  = cwr_ptr;
                        w_state_n = W_DROP;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_n = wr_ptr + 1'b1;
                        if (w_state == W_HDR) begin
                            w_len_n   = wr_data[LEN_LSB +: LEN_BITS];
                            w_cnt_n   = '0;
                            w_state_n = W_BODY;
                        end else begin
                            w_cnt_n = w_cnt + 1'b1;
                        end
                    end
                end
            end
            W_DROP: begin
                if (wr_sop) begin
                    drop      = 1'b1;
                    w_state_n = W_HDR;
                end else if (wr_eop) begin
                    drop      = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Output handshake: a marker or word is transferred exactly in the cycles where
    // out_ready is high; sop, vld and eop are only ever asserted in such cycles.
    always_comb begin
        r_state_n = r_state;
        rd_ptr_n  = rd_ptr;
        r_cnt_n   = r_cnt;
        rd_start  = 1'b0;
        out_sop   = 1'b0;
        out_vld   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        case (r_state)
            R_IDLE: begin
                if (pend != '0) begin
                    rd_start  = 1'b1;
                    r_state_n = R_SOP;
                end
            end
            R_SOP: begin
                if (out_ready) begin
                    out_sop   = 1'b1;
                    r_cnt_n   = '0;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (out_ready) begin
                    out_vld  = 1'b1;
                    out_data = rd_word;
                    rd_ptr_n = rd_ptr + 1'b1;
                    r_cnt_n  = r_cnt + 1'b1;
                    if (r_cnt == CW'(r_len)) r_state_n = R_EOP;
                end
            end
            R_EOP: begin
                if (out_ready) begin
                    out_eop   = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            wr_ptr   <= '0;
            cwr_ptr  <= '0;
            rd_ptr   <= '0;
            w_cnt    <= '0;
            w_len    <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            pend     <= '0;
            out_dest <= '0;
            out_pri  <= '0;
            pause    <= 1'b0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
            wr_ptr  <= wr_ptr_n;
            cwr_ptr <= cwr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            w_cnt   <= w_cnt_n;
            w_len   <= w_len_n;
            r_cnt   <= r_cnt_n;
            // Pause tracks the post-edge fill level so it always matches free_words.
            pause   <= (free_n < PW'(PAUSE_TH));
            if (rd_start) begin
                out_dest <= rd_word[PORT_BITS-1:0];
                out_pri  <= rd_word[PORT_BITS +: PRI_BITS];
                r_len    <= rd_word[LEN_LSB +: LEN_BITS];
            end
            if (commit && !rd_start)      pend <= pend + 1'b1;
            else if (!commit && rd_start) pend <= pend - 1'b1;
            if (commit && pkt_cnt != 16'hFFFF)  pkt_cnt  <= pkt_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF)   drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: doc/hydra_ingress_buffer.md
HYDRA_INGRESS_BUFFER -- requirements
Module: hydra_ingress_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of every data word.
REQ-002 Parameter PORT_BITS, default 4: destination field width, header bits [PORT_BITS-1:0].
REQ-003 Parameter PRI_BITS, default 3: priority field width, header bits directly above the destination field.
REQ-004 Parameter LEN_BITS, default 9: payload-length field width, header bits directly above the priority field; DATA_WIDTH >= LEN_BITS+PRI_BITS+PORT_BITS.
REQ-005 Parameter DEPTH, default 256, power of two: buffer capacity in words.
REQ-006 Parameter PAUSE_TH, default 32: free-word level below which pause asserts.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 wr_sop  input  1  one-cycle packet start marker.
REQ-010 wr_vld  input  1  wr_data valid this cycle.
REQ-011 wr_data  input  DATA_WIDTH  first valid word is the header, then payload words.
REQ-012 wr_eop  input  1  one-cycle packet end marker, after the last valid word.
REQ-013 pause  output  1  upstream must stop starting packets.
REQ-014 out_ready  input  1  downstream accepts output this cycle.
REQ-015 out_sop, out_vld, out_eop  output  1 each  output framing, same protocol as the input.
REQ-016 out_data  output  DATA_WIDTH  output word, valid with out_vld.
REQ-017 out_dest, out_pri  output  PORT_BITS, PRI_BITS  fields of the packet being emitted, held from out_sop through out_eop.
REQ-018 pkt_cnt, drop_cnt  output  16 each  saturating counts of committed and dropped packets.
REQ-019 free_words  output  $clog2(DEPTH)+1  DEPTH minus words held, in-flight packet words included.

Function
REQ-020 Write FSM states: W_IDLE, W_HDR, W_BODY, W_DROP; the FSM leaves W_IDLE only on wr_sop.
REQ-021 W_HDR: first wr_vld word is stored, LEN latched, payload counter cleared, next state W_BODY.
REQ-022 W_BODY: each wr_vld word is stored and the counter increments; wr_eop returns the FSM to W_IDLE.
REQ-023 Commit on wr_eop only if payload count == LEN; the committed write pointer then advances to the write pointer and pkt_cnt increments.
REQ-024 On wr_eop with count != LEN, the write pointer rolls back to the committed pointer and drop_cnt increments.
REQ-025 If a word would arrive with free_words == 0, roll back, enter W_DROP, and discard words until wr_eop; on that wr_eop drop_cnt increments once and the FSM returns to W_IDLE.
REQ-026 wr_sop in W_HDR or W_BODY drops the open packet (rollback, drop_cnt+1) and starts a new packet in W_HDR in the same cycle.
REQ-027 In W_HDR, wr_eop drops an empty packet (drop_cnt+1).
REQ-028 wr_vld in W_IDLE is ignored.
REQ-029 The read side sees only committed words; a committed packet is eligible the cycle after commit.
REQ-030 Read FSM states: R_IDLE, R_SOP, R_DATA, R_EOP.
REQ-031 R_IDLE -> R_SOP when at least one committed packet is pending.
REQ-032 R_SOP: out_sop=1, out_dest/out_pri loaded from the header; the FSM advances only when out_ready=1.
REQ-033 R_DATA: one word per out_ready cycle, header first, then LEN payload words.
REQ-034 R_EOP: out_eop=1 for one out_ready cycle, then the FSM returns to R_IDLE.
REQ-035 out_vld=0 whenever out_ready=0; no word is lost or repeated across stalls.
REQ-036 Minimum output gap between packets is one idle cycle; the bus never emits sop/vld/eop in the same cycle.
REQ-037 Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty derive from the MSB compare.
REQ-038 Simultaneous write-commit and read-release in one cycle update free_words by both amounts.
REQ-039 pause is registered and equals (free_words < PAUSE_TH); it does not gate wr_vld.
REQ-040 pkt_cnt and drop_cnt saturate at 16'hFFFF.

Reset
REQ-041 rst asserted: both FSMs go to idle, all pointers go to 0, and buffer contents are discarded.
REQ-042 rst asserted: out_sop/out_vld/out_eop=0, out_data/out_dest/out_pri=0, pause=0, pkt_cnt=drop_cnt=0, free_words=DEPTH.
REQ-043 Reset mid-packet, on either side, drops the packet silently with no counter change.

Verification
REQ-044 Good packet: header 16'h0FC3 (len 31, pri 4, dest 3) + 31 words, out_ready=1 -> pkt_cnt=1; out_sop with dest=3, pri=4; 32 out_vld words identical; then out_eop.
REQ-045 Length mismatch: header len 56 + 55 words -> drop_cnt=1, no output, free_words returns to 256.
REQ-046 Overflow with DEPTH=64, PAUSE_TH=16: header len 128 + 128 words -> pause=1 once free_words<16; W_DROP entered; drop_cnt=1; free_words=64 after eop.
REQ-047 Back-to-back packets of len 56, 56, 54 with out_ready toggling 1-0 -> three packets out in order, words intact, pkt_cnt=3.
REQ-048 Missing eop: sop, header len 10, 4 words, then a new sop with a valid len-5 packet -> drop_cnt=1, pkt_cnt=1, only the len-5 packet is output.
REQ-049 rst pulse during R_DATA of a committed packet -> outputs 0 on the next edge, free_words=DEPTH, no further output.
